// File: rtl/vec_alu_pkg.sv
// Shared opcode enum, default widths and lane type for the vector ALU pipeline.
// Optional reduce feature is controlled by macro VEC_ALU_REDUCE_EN.
package vec_alu_pkg;

   localparam int OPW_DEFAULT = 5;
   localparam int EW_DEFAULT  = 8;

   typedef logic [EW_DEFAULT-1:0] lane_t;

   typedef enum logic [OPW_DEFAULT-1:0] {
      VOP_PASS = 5'd0,
      VOP_ADD  = 5'd1,
      VOP_SUB  = 5'd2,
      VOP_XOR  = 5'd3,
      VOP_AND  = 5'd4,
      VOP_OR   = 5'd5,
      VOP_ROTL = 5'd6,
      VOP_ROTR = 5'd7,
      VOP_SHL  = 5'd8,
      VOP_SHR  = 5'd9,
      VOP_HSUM = 5'd10
   } vop_e;

endpackage

// File: rtl/vec_lane_alu.sv
// One lane of the vector ALU: purely combinational, EW-bit operands, no cross-lane carry.
// HSUM is not handled here; unknown opcodes yield zero.
module vec_lane_alu
   import vec_alu_pkg::*;
#(
   parameter int EW  = 8,
   parameter int OPW = OPW_DEFAULT
) (
   input  logic [OPW-1:0] op,
   input  logic [EW-1:0]  a,
   input  logic [EW-1:0]  b,
   output logic [EW-1:0]  y
);

   localparam int             SW   = $clog2(EW);
   localparam logic [EW-1:0]  EW_L = EW'(EW);

   logic [SW-1:0]   amt;
   logic [2*EW-1:0] rot_l;
   logic [2*EW-1:0] rot_r;

   always_comb begin
      // Rotating a doubled copy keeps the rotate a plain shift for any EW.
      amt   = b[SW-1:0];
      rot_l = {a, a} << amt;
      rot_r = {a, a} >> amt;
      y     = '0;
      case (op)
         OPW'(VOP_PASS): y = a;
         OPW'(VOP_ADD):  y = a + b;
         OPW'(VOP_SUB):  y = a - b;
         OPW'(VOP_XOR):  y = a ^ b;
         OPW'(VOP_AND):  y = a & b;
         OPW'(VOP_OR):   y = a | b;
         OPW'(VOP_ROTL): y = rot_l[2*EW-1:EW];
         OPW'(VOP_ROTR): y = rot_r[EW-1:0];
         OPW'(VOP_SHL):  y = (b >= EW_L) ? '0 : a << b;
         OPW'(VOP_SHR):  y = (b >= EW_L) ? '0 : a >> b;
         default:        y = '0;
      endcase
   end

endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage handshaked vector ALU with flush and completed-op counter.
// Define VEC_ALU_REDUCE_EN to build the HSUM adder tree (op 10).
module vec_alu_pipe
   import vec_alu_pkg::*;
#(
   parameter int LANES = 16,
   parameter int EW    = 8,
   parameter int OPW   = OPW_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPW-1:0]      op,
   input  logic [LANES*EW-1:0] src_a,
   input  logic [LANES*EW-1:0] src_b,
   input  logic [4:0]          rd_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES*EW-1:0] result,
   output logic [4:0]          rd_out,
   output logic [31:0]         op_count
);

   localparam int W = LANES * EW;

   logic          adv1, adv2, accept;
   logic          s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [OPW-1:0] s1_op_q, s1_op_d;
   logic [W-1:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic [4:0]    s1_rd_q, s1_rd_d, rd_out_q, rd_out_d;
   logic [W-1:0]  result_q, result_d;
   logic [31:0]   op_count_q, op_count_d;
   logic [W-1:0]  lane_res, s2_res;

   for (genvar i = 0; i < LANES; i++) begin : gen_lane
      vec_lane_alu #(.EW(EW), .OPW(OPW)) u_lane (
         .op (s1_op_q),
         .a  (s1_a_q[i*EW +: EW]),
         .b  (s1_b_q[i*EW +: EW]),
         .y  (lane_res[i*EW +: EW])
      );
   end

`ifdef VEC_ALU_REDUCE_EN
   localparam int HALF = LANES / 2;

   logic [EW-1:0] psum_q [HALF];
   logic [EW-1:0] psum_d [HALF];
   logic [EW-1:0] hsum;

   always_comb begin
      for (int i = 0; i < HALF; i++) begin
         psum_d[i] = accept ? src_a[2*i*EW +: EW] + src_a[(2*i+1)*EW +: EW] : psum_q[i];
      end
      hsum = '0;
      for (int i = 0; i < HALF; i++) begin
         hsum = hsum + psum_q[i];
      end
      s2_res = lane_res;
      if (s1_op_q == OPW'(VOP_HSUM)) begin
         s2_res = W'(hsum);
      end
   end

   always_ff @(posedge clk) begin
      psum_q <= psum_d;
   end
`else
   always_comb begin
      s2_res = lane_res;
   end
`endif

   always_comb begin
      adv2     = !s2_valid_q || out_ready;
      adv1     = !s1_valid_q || adv2;
      in_ready = adv1 && !flush;
      accept   = in_valid && in_ready;

      s1_valid_d = flush ? 1'b0 : (adv1 ? accept : s1_valid_q);
      s2_valid_d = flush ? 1'b0 : (adv2 ? s1_valid_q : s2_valid_q);

      s1_op_d = accept ? op    : s1_op_q;
      s1_a_d  = accept ? src_a : s1_a_q;
      s1_b_d  = accept ? src_b : s1_b_q;
      s1_rd_d = accept ? rd_in : s1_rd_q;

      result_d = result_q;
      rd_out_d = rd_out_q;
      if (adv2 && s1_valid_q && !flush) begin
         result_d = s2_res;
         rd_out_d = s1_rd_q;
      end

      op_count_d = op_count_q + 32'(s2_valid_q && out_ready && !flush);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         rd_out_q   <= '0;
         op_count_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         rd_out_q   <= rd_out_d;
         op_count_q <= op_count_d;
      end
   end

   // NOTE: S1 payload is qualified by s1_valid_q, so it needs no reset and stays a plain register.
   always_ff @(posedge clk) begin
      s1_op_q <= s1_op_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_rd_q <= s1_rd_d;
   end

   assign out_valid = s2_valid_q;
   assign result    = result_q;
   assign rd_out    = rd_out_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Self-checking bench for vec_alu_pipe: directed scenarios plus randomized traffic
// against a two-slot behavioural model with integer-arithmetic lane reference.
module tb_vec_alu_pipe;
   import vec_alu_pkg::*;

   localparam int LANES = 16;
   localparam int EW    = 8;
   localparam int W     = LANES * EW;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic          in_ready, out_valid;
   logic [4:0]    op, rd_in, rd_out;
   logic [W-1:0]  src_a, src_b, result;
   logic [31:0]   op_count;

   vec_alu_pipe #(.LANES(LANES), .EW(EW), .OPW(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src_a     (src_a),
      .src_b     (src_b),
      .rd_in     (rd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .rd_out    (rd_out),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           v;
      logic [W-1:0] res;
      logic [4:0]   rd;
   } slot_t;

   slot_t       m1, m2;
   int unsigned m_cnt;
   int          n_cmp = 0;
   int          n_err = 0;
   bit          seen_in_ready;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic longint ref_lane(input int opc, input longint a, input longint b);
      longint m = (longint'(1) << EW) - 1;
      int     sh;
      case (opc)
         0: return a;
         1: return (a + b) & m;
         2: return (a - b) & m;
         3: return a ^ b;
         4: return a & b;
         5: return a | b;
         6: begin sh = int'(b % EW); return ((a << sh) | (a >> (EW - sh))) & m; end
         7: begin sh = int'(b % EW); return ((a >> sh) | (a << (EW - sh))) & m; end
         8: return (b >= EW) ? 0 : (a << b) & m;
         9: return (b >= EW) ? 0 : (a >> b);
         default: return 0;
      endcase
   endfunction

   function automatic logic [W-1:0] ref_vec(input int opc, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      longint       s;
      for (int i = 0; i < LANES; i++) begin
         r[i*EW +: EW] = EW'(ref_lane(opc, longint'(a[i*EW +: EW]), longint'(b[i*EW +: EW])));
      end
`ifdef VEC_ALU_REDUCE_EN
      if (opc == 10) begin
         s = 0;
         for (int i = 0; i < LANES; i++) s += longint'(a[i*EW +: EW]);
         r = '0;
         r[EW-1:0] = EW'(s);
      end
`else
      s = 0;
`endif
      return r;
   endfunction

   function automatic logic [W-1:0] bcast(input lane_t v);
      return {LANES{v}};
   endfunction

   // One clock: drive at negedge, compare against the model, then advance the model at posedge.
   task automatic step(input bit iv, input logic [4:0] op_i, input logic [W-1:0] a_i,
                       input logic [W-1:0] b_i, input logic [4:0] rd_i,
                       input bit ordy, input bit fl, input bit rst);
      bit adv1m, adv2m, acc;
      @(negedge clk);
      in_valid  = iv;
      op        = op_i;
      src_a     = a_i;
      src_b     = b_i;
      rd_in     = rd_i;
      out_ready = ordy;
      flush     = fl;
      reset     = rst;
      #1;
      adv2m = !m2.v || ordy;
      adv1m = !m1.v || adv2m;
      acc   = iv && adv1m && !fl;
      seen_in_ready = in_ready;
      check("in_ready", W'(in_ready), W'(adv1m && !fl));
      check("out_valid", W'(out_valid), W'(m2.v));
      if (m2.v) begin
         check("result", result, m2.res);
         check("rd_out", W'(rd_out), W'(m2.rd));
      end
      check("op_count", W'(op_count), W'(m_cnt));
      @(posedge clk);
      if (rst) begin
         m1.v = 0; m2.v = 0; m_cnt = 0;
      end else if (fl) begin
         m1.v = 0; m2.v = 0;
      end else begin
         if (m2.v && ordy) m_cnt++;
         if (adv2m) m2 = m1;
         if (adv1m) begin
            m1.v   = acc;
            m1.res = ref_vec(int'(op_i), a_i, b_i);
            m1.rd  = rd_i;
         end
      end
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, 5'd0, '0, '0, 5'd0, ordy, 1'b0, 1'b0);
   endtask

   task automatic lane_case(input string tag, input logic [4:0] opc, input lane_t a, input lane_t b, input lane_t exp);
      step(1'b1, opc, bcast(a), bcast(b), 5'd7, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      #1;
      check({tag, "_valid"}, W'(out_valid), W'(1'b1));
      check(tag, result, bcast(exp));
   endtask

   initial begin
      logic [W-1:0] a_v, b_v;
      int unsigned  base;
      int           opc;

      in_valid = 0; op = '0; src_a = '0; src_b = '0; rd_in = '0;
      out_ready = 1; flush = 0; reset = 1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", W'(out_valid), '0);
      check("rst_result", result, '0);
      check("rst_rd_out", W'(rd_out), '0);
      check("rst_op_count", W'(op_count), '0);
      m1.v = 0; m2.v = 0; m_cnt = 0;
      idle(1'b1);

      // ADD wrap, no cross-lane carry
      lane_case("add_wrap", VOP_ADD, 8'hF0, 8'h20, 8'h10);
      // Rotates and shifts
      lane_case("rotl", VOP_ROTL, 8'h81, 8'd9, 8'h03);
      lane_case("rotr", VOP_ROTR, 8'h01, 8'd1, 8'h80);
      lane_case("shr_ge_ew", VOP_SHR, 8'hFF, 8'd8, 8'h00);
      lane_case("shl", VOP_SHL, 8'h01, 8'd7, 8'h80);
      lane_case("unknown_op", 5'd17, 8'h5A, 8'h11, 8'h00);
      idle(1'b1);

      // Back-pressure: two accepted, third stalls, then drains in order
      base = m_cnt;
      step(1'b1, VOP_ADD, bcast(8'h01), bcast(8'h02), 5'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, VOP_XOR, bcast(8'h0F), bcast(8'hF0), 5'd2, 1'b0, 1'b0, 1'b0);
      #1;
      check("bp_in_ready_low", W'(in_ready), '0);
      repeat (2) step(1'b1, VOP_SUB, bcast(8'h10), bcast(8'h01), 5'd3, 1'b0, 1'b0, 1'b0);
      #1;
      check("bp_hold_result", result, bcast(8'h03));
      check("bp_hold_rd", W'(rd_out), W'(5'd1));
      step(1'b1, VOP_SUB, bcast(8'h10), bcast(8'h01), 5'd3, 1'b1, 1'b0, 1'b0);
      #1;
      check("bp_op2", result, bcast(8'hFF));
      idle(1'b1);
      #1;
      check("bp_op3", result, bcast(8'h0F));
      idle(1'b1);
      #1;
      check("bp_count", W'(op_count), W'(base + 3));

      // Flush kills the accepted XOR and blocks the concurrent beat
      base = m_cnt;
      step(1'b1, VOP_XOR, bcast(8'hAA), bcast(8'h55), 5'd4, 1'b1, 1'b0, 1'b0);
      step(1'b1, VOP_ADD, bcast(8'h01), bcast(8'h01), 5'd5, 1'b1, 1'b1, 1'b0);
      check("flush_in_ready", W'(seen_in_ready), '0);
      repeat (3) begin
         idle(1'b1);
         #1;
         check("flush_no_valid", W'(out_valid), '0);
      end
      check("flush_count", W'(op_count), W'(base));

      // Reset mid-stream
      step(1'b1, VOP_OR, bcast(8'h0C), bcast(8'h30), 5'd6, 1'b1, 1'b0, 1'b0);
      step(1'b1, VOP_AND, bcast(8'h0C), bcast(8'h3C), 5'd7, 1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd0, '0, '0, 5'd0, 1'b1, 1'b0, 1'b1);
      #1;
      check("midrst_valid", W'(out_valid), '0);
      check("midrst_result", result, '0);
      check("midrst_count", W'(op_count), '0);
      idle(1'b1);
      #1;
      check("midrst_still_idle", W'(out_valid), '0);
      lane_case("post_rst_add", VOP_ADD, 8'h33, 8'h44, 8'h77);

`ifdef VEC_ALU_REDUCE_EN
      for (int i = 0; i < LANES; i++) a_v[i*EW +: EW] = EW'(i + 1);
      step(1'b1, VOP_HSUM, a_v, '0, 5'd9, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      #1;
      b_v = '0;
      b_v[7:0] = 8'h88;
      check("hsum", result, b_v);
`endif

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < W / 32; i++) begin
            a_v[i*32 +: 32] = $urandom;
            b_v[i*32 +: 32] = $urandom;
         end
         if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < LANES; i++) b_v[i*EW +: EW] = EW'($urandom_range(0, 12));
         end
         opc = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 10));
         step(bit'($urandom_range(0, 3) != 0), 5'(opc), a_v, b_v, 5'($urandom),
              bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 19) == 0),
              bit'($urandom_range(0, 99) == 0));
      end
      repeat (3) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
